// File: rtl/prog_inst_mem_pkg.sv
// prog_inst_mem_pkg: shared FSM encodings, clog2 helper and NOP constant.
package prog_inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [63:0] NOP = '0;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_inst_mem_ram.sv
// inst_byte_ram: byte array with one synchronous write port and PORTS
// consecutive, address-wrapping asynchronous read ports.
module inst_byte_ram #(
    parameter int ADDR_W = 10,
    parameter int BYTE_W = 8,
    parameter int PORTS  = 4
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [BYTE_W-1:0]             wdata,
    input  logic [ADDR_W-1:0]             raddr,
    output logic [PORTS-1:0][BYTE_W-1:0]  rdata
);

    // Zero start-up contents exist for simulation; hardware leaves them undefined.
    logic [BYTE_W-1:0] mem [2**ADDR_W] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    for (genvar k = 0; k < PORTS; k++) begin : g_rd
        assign rdata[k] = mem[raddr + ADDR_W'(k)];
    end

endmodule

// File: rtl/prog_inst_mem.sv
// prog_inst_mem: byte-addressed instruction memory with a streaming program
// loader (valid/ready, HALT or full-memory termination) and a registered fetch port.
module prog_inst_mem
    import prog_inst_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int BYTE_W     = 8,
    parameter int INST_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter logic [INST_BYTES*BYTE_W-1:0] HALT_INST = '1
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_fetch_enable,
    input  logic [ADDR_W-1:0]            i_fetch_addr,
    output logic [INST_BYTES*BYTE_W-1:0] o_inst,
    output logic                         o_inst_valid,
    output logic                         o_misaligned,
    input  logic                         i_load_start,
    input  logic [BYTE_W-1:0]            i_load_byte,
    input  logic                         i_load_valid,
    output logic                         o_load_ready,
    output logic                         o_load_done,
    output logic                         o_load_overflow,
    output logic [ADDR_W:0]              o_load_count
);

    localparam int INST_W = INST_BYTES * BYTE_W;
    localparam int LB     = clog2(INST_BYTES);

    state_t state, state_nx;
    logic [ADDR_W:0] count_nx;
    logic [INST_W-1:0] asm_q, asm_nx, word;
    logic [INST_BYTES-1:0][BYTE_W-1:0] rdata;
    logic start, accept, halt, last, misaligned;

    assign start      = state != LOAD && i_load_start;
    assign accept     = state == LOAD && i_load_valid;
    assign count_nx   = o_load_count + 1'b1;
    assign asm_nx     = BIG_ENDIAN ? (asm_q << BYTE_W) | INST_W'(i_load_byte)
                                   : (asm_q >> BYTE_W) | (INST_W'(i_load_byte) << (INST_W - BYTE_W));
    // HALT is only recognised on whole-instruction boundaries and beats overflow.
    assign halt       = accept && count_nx[LB-1:0] == '0 && asm_nx == HALT_INST;
    assign last       = accept && o_load_count[ADDR_W-1:0] == '1;
    assign misaligned = i_fetch_addr[LB-1:0] != '0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == LOAD ? ((halt || last) ? DONE : LOAD)
                                 : (i_load_start ? LOAD : state);
    end

    always_comb begin
        o_load_ready = state == LOAD;
        o_load_done  = state == DONE;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_load_count    <= '0;
            asm_q           <= '0;
            o_load_overflow <= 1'b0;
        end else if (start) begin
            o_load_count    <= '0;
            asm_q           <= '0;
            o_load_overflow <= 1'b0;
        end else if (accept) begin
            o_load_count    <= count_nx;
            asm_q           <= asm_nx;
            o_load_overflow <= last && !halt;
        end
    end

    inst_byte_ram #(
        .ADDR_W(ADDR_W),
        .BYTE_W(BYTE_W),
        .PORTS (INST_BYTES)
    ) u_ram (
        .clk  (i_clock),
        .we   (accept),
        .waddr(o_load_count[ADDR_W-1:0]),
        .wdata(i_load_byte),
        .raddr(i_fetch_addr),
        .rdata(rdata)
    );

    for (genvar k = 0; k < INST_BYTES; k++) begin : g_word
        localparam int P = BIG_ENDIAN ? INST_BYTES - 1 - k : k;
        assign word[P*BYTE_W +: BYTE_W] = rdata[k];
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset || state == LOAD) begin
            o_inst       <= '0;
            o_inst_valid <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (i_fetch_enable) begin
            o_inst       <= misaligned ? INST_W'(NOP) : word;
            o_inst_valid <= 1'b1;
            o_misaligned <= misaligned;
        end
    end

endmodule

// File: tb/tb_prog_inst_mem.sv
// tb_prog_inst_mem: three configurations (BE/4, LE/4, BE/2) share one stimulus
// stream and are checked every cycle against a byte-level behavioural model.
module tb_prog_inst_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fe = 1'b0, lstart = 1'b0, lvalid = 1'b0;
    logic [9:0] faddr = '0;
    logic [7:0] lbyte = '0;
    logic [31:0] inst0, inst1;
    logic [15:0] inst2;
    logic [2:0] vld, mis, rdy, dn, ovf;
    logic [10:0] cnt [3];
    int n_chk = 0, n_fail = 0;
    bit on = 1'b0;

    always #5 clk = ~clk;

    prog_inst_mem dut0 (
        .i_clock(clk), .i_reset(rst), .i_fetch_enable(fe), .i_fetch_addr(faddr),
        .o_inst(inst0), .o_inst_valid(vld[0]), .o_misaligned(mis[0]),
        .i_load_start(lstart), .i_load_byte(lbyte), .i_load_valid(lvalid),
        .o_load_ready(rdy[0]), .o_load_done(dn[0]), .o_load_overflow(ovf[0]),
        .o_load_count(cnt[0]));

    prog_inst_mem #(.BIG_ENDIAN(1'b0)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_fetch_enable(fe), .i_fetch_addr(faddr),
        .o_inst(inst1), .o_inst_valid(vld[1]), .o_misaligned(mis[1]),
        .i_load_start(lstart), .i_load_byte(lbyte), .i_load_valid(lvalid),
        .o_load_ready(rdy[1]), .o_load_done(dn[1]), .o_load_overflow(ovf[1]),
        .o_load_count(cnt[1]));

    prog_inst_mem #(.INST_BYTES(2)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_fetch_enable(fe), .i_fetch_addr(faddr),
        .o_inst(inst2), .o_inst_valid(vld[2]), .o_misaligned(mis[2]),
        .i_load_start(lstart), .i_load_byte(lbyte), .i_load_valid(lvalid),
        .o_load_ready(rdy[2]), .o_load_done(dn[2]), .o_load_overflow(ovf[2]),
        .o_load_count(cnt[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: 0 = idle, 1 = loading, 2 = done; HALT = an aligned run of all-FF bytes.
    int ib [3] = '{4, 4, 2};
    bit be [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] mmem [3][1024];
    int ms [3], mc [3], run [3];
    bit mov [3], mv [3], mm [3];
    logic [31:0] mi [3];
    logic [7:0] mb;

    initial begin
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 1024; a++)
                mmem[i][a] = 8'h00;
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                ms[i] = 0; mc[i] = 0; mov[i] = 0; mi[i] = 0; mv[i] = 0; mm[i] = 0;
            end else if (ms[i] == 1) begin
                mi[i] = 0; mv[i] = 0; mm[i] = 0;
                if (lvalid) begin
                    mmem[i][mc[i]] = lbyte;
                    mc[i]++;
                    run[i] = (lbyte == 8'hFF) ? run[i] + 1 : 0;
                    if (mc[i] % ib[i] == 0 && run[i] >= ib[i])
                        ms[i] = 2;
                    else if (mc[i] == 1024) begin
                        ms[i] = 2;
                        mov[i] = 1;
                    end
                end
            end else begin
                if (fe) begin
                    mv[i] = 1;
                    mm[i] = (int'(faddr) % ib[i]) != 0;
                    mi[i] = 0;
                    if (!mm[i])
                        for (int k = 0; k < ib[i]; k++) begin
                            mb = mmem[i][(int'(faddr) + k) % 1024];
                            mi[i] = be[i] ? (mi[i] << 8) | 32'(mb) : mi[i] | (32'(mb) << (8 * k));
                        end
                end
                if (lstart) begin
                    ms[i] = 1; mc[i] = 0; mov[i] = 0; run[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (on)
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("d%0d_inst", i),
                    i == 0 ? inst0 : i == 1 ? inst1 : {16'h0, inst2},
                    i == 2 ? {16'h0, mi[2][15:0]} : mi[i]);
                chk($sformatf("d%0d_valid", i), vld[i], mv[i]);
                chk($sformatf("d%0d_mis", i), mis[i], mm[i]);
                chk($sformatf("d%0d_ready", i), rdy[i], ms[i] == 1);
                chk($sformatf("d%0d_done", i), dn[i], ms[i] == 2);
                chk($sformatf("d%0d_ovf", i), ovf[i], mov[i]);
                chk($sformatf("d%0d_count", i), cnt[i], mc[i]);
            end
    end

    function automatic logic [7:0] pat(input int i);
        return i == 0 ? 8'h01 : i == 1 ? 8'h02 : i == 1022 ? 8'hAA : i == 1023 ? 8'hBB : 8'(i % 255);
    endfunction

    logic [7:0] prog [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    int idx;
    bit acc;

    initial begin
        repeat (2) @(negedge clk);
        on = 1'b1;
        chk("rst_count", cnt[0], 0);
        chk("rst_done", dn[0], 0);
        rst = 1'b0;
        lstart = 1'b1;
        @(negedge clk);
        lstart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lvalid = 1'b1;
            lbyte = prog[i];
            @(negedge clk);
        end
        lvalid = 1'b0;
        chk("load_done", dn[0], 1);
        chk("load_count", cnt[0], 8);
        chk("load_ovf", ovf[0], 0);
        chk("load_count_ib2", cnt[2], 6);
        fe = 1'b1;
        faddr = 10'd0;
        @(negedge clk);
        chk("fetch0_be", inst0, 32'h01020304);
        chk("fetch0_le", inst1, 32'h04030201);
        chk("fetch0_ib2", inst2, 16'h0102);
        chk("fetch0_valid", vld[0], 1);
        faddr = 10'd4;
        @(negedge clk);
        chk("fetch4", inst0, 32'hFFFFFFFF);
        faddr = 10'd2;
        @(negedge clk);
        chk("fetch2_mis", mis[0], 1);
        chk("fetch2_nop", inst0, 0);
        chk("fetch2_valid", vld[0], 1);
        chk("fetch2_ib2", inst2, 16'h0304);
        fe = 1'b0;
        faddr = 10'd0;
        @(negedge clk);
        faddr = 10'd4;
        @(negedge clk);
        chk("stall_inst", inst0, 0);
        chk("stall_mis", mis[0], 1);
        chk("stall_ib2", inst2, 16'h0304);
        lstart = 1'b1;
        @(negedge clk);
        lstart = 1'b0;
        idx = 0;
        for (int c = 0; c < 5000 && idx < 1024; c++) begin
            lvalid = 1'($urandom % 2);
            lbyte = pat(idx);
            acc = lvalid && rdy[0];
            @(negedge clk);
            if (acc)
                idx++;
        end
        lvalid = 1'b0;
        chk("ovf_bytes", idx, 1024);
        chk("ovf_count", cnt[0], 1024);
        chk("ovf_flag", ovf[0], 1);
        chk("ovf_done", dn[0], 1);
        fe = 1'b1;
        faddr = 10'd1022;
        @(negedge clk);
        chk("wrap_mis", mis[0], 1);
        chk("wrap_nop", inst0, 0);
        chk("wrap_ib2", inst2, 16'hAABB);
        faddr = 10'd0;
        @(negedge clk);
        chk("reload0", inst0, 32'h01020203);
        fe = 1'b0;
        lstart = 1'b1;
        @(negedge clk);
        lstart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lvalid = 1'b1;
            lbyte = 8'(8'h11 + i);
            @(negedge clk);
        end
        lvalid = 1'b0;
        chk("mid_count", cnt[0], 6);
        #1 rst = 1'b1;
        #1;
        chk("arst_count", cnt[0], 0);
        chk("arst_ready", rdy[0], 0);
        chk("arst_done", dn[0], 0);
        chk("arst_ovf", ovf[0], 0);
        chk("arst_valid", vld[0], 0);
        chk("arst_inst", inst0, 0);
        @(negedge clk);
        rst = 1'b0;
        fe = 1'b1;
        faddr = 10'd0;
        @(negedge clk);
        chk("post_rst_be", inst0, 32'h11121314);
        chk("post_rst_le", inst1, 32'h14131211);
        chk("post_rst_ib2", inst2, 16'h1112);
        chk("post_rst_idle", rdy[0], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
